// File: rtl/stream_delay_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_delay_pkg
//  Description : Shared types for the stream delay FIFO. The delay_mode_e
//                enum selects where each beat's release delay comes from.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_delay_pkg;

  // Source of the per-beat delay loaded into an entry on push.
  typedef enum logic [1:0] {
    DelayFixed  = 2'd0,  // constant FixedDelay
    DelayRandom = 2'd1,  // low bits of a free-running-on-push LFSR
    DelayPort   = 2'd2   // delay_i sampled on the input handshake
  } delay_mode_e;

  // Width of the LFSR that backs DelayRandom.
  localparam int unsigned LfsrWidth = 16;

endpackage : stream_delay_pkg
`default_nettype wire

// File: rtl/stream_delay_fifo_lfsr_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_16bit
//  Description : 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1 (shift
//                right, feedback into bit 15). Advances only when en_i is
//                high; value_o exposes the low OutWidth bits of the current
//                state, i.e. the value before the advance caused by en_i.
//  Ports       : clk_i    - clock
//                rst_ni   - asynchronous reset, active-low (loads Seed)
//                en_i     - advance strobe
//                value_o  - low OutWidth bits of the current state
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_16bit #(
  parameter logic [15:0] Seed     = 16'h0001,
  parameter int unsigned OutWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  output logic [OutWidth-1:0] value_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic        feedback;

  always_comb begin
    feedback = state_q[0] ^ state_q[2] ^ state_q[3] ^ state_q[5];
    state_d  = state_q;
    if (en_i) begin
      state_d = {feedback, state_q[15:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign value_o = state_q[OutWidth-1:0];

endmodule : lfsr_16bit
`default_nettype wire

// File: rtl/stream_delay_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_delay_fifo
//  Description : In-order valid/ready buffer of Depth entries. Each accepted
//                beat carries a down-counter loaded with its delay; the head
//                is offered once its counter reaches zero. All counters run
//                every cycle, so several beats age in parallel and the block
//                sustains one beat per cycle.
//  Ports       : clk_i     - clock
//                rst_i     - asynchronous reset, active-high
//                clear_i   - synchronous flush of all entries
//                payload_i - input payload
//                valid_i   - input valid
//                ready_o   - input ready (= not full)
//                delay_i   - per-beat delay (DelayPort mode only)
//                payload_o - payload of the head entry
//                valid_o   - head occupied and its delay expired
//                ready_i   - output ready
//                usage_o   - number of occupied entries
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_delay_fifo
  import stream_delay_pkg::*;
#(
  parameter type         payload_t  = logic,
  parameter int unsigned Depth      = 4,
  parameter int unsigned DelayWidth = 4,
  parameter delay_mode_e DelayMode  = DelayFixed,
  parameter int unsigned FixedDelay = 1,
  parameter logic [15:0] Seed       = 16'h0001
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  payload_t                   payload_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DelayWidth-1:0]      delay_i,
  output payload_t                   payload_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(Depth+1)-1:0] usage_o
);

  localparam int unsigned PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned UsageWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
  localparam logic [UsageWidth-1:0] FullUsage = UsageWidth'(Depth);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (Depth < 1) begin : g_chk_depth
    $fatal(1, "stream_delay_fifo: Depth must be >= 1");
  end
  if ((FixedDelay >> DelayWidth) != 0) begin : g_chk_fixed
    $fatal(1, "stream_delay_fifo: FixedDelay must be < 2**DelayWidth");
  end
  if ((DelayMode == DelayRandom) && (Seed == 16'h0000)) begin : g_chk_seed
    $fatal(1, "stream_delay_fifo: Seed must be non-zero in DelayRandom");
  end
  if ((DelayMode == DelayRandom) && (DelayWidth > LfsrWidth)) begin : g_chk_lfsr_w
    $fatal(1, "stream_delay_fifo: DelayWidth exceeds LFSR width");
  end

  // --------------------------------------------------------------------------
  // Storage and control state
  // --------------------------------------------------------------------------
  payload_t              payload_mem_q [Depth];
  payload_t              payload_mem_d [Depth];
  logic [DelayWidth-1:0] count_q       [Depth];
  logic [DelayWidth-1:0] count_d       [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [UsageWidth-1:0] usage_q, usage_d;

  logic                  push_en;
  logic                  pop_en;
  logic [DelayWidth-1:0] push_delay;
  logic [DelayWidth-1:0] lfsr_delay;

  // ready_o depends only on occupancy: a full buffer refuses input even in a
  // cycle where the head leaves, which keeps ready_i off the ready_o path.
  assign ready_o   = (usage_q != FullUsage);
  assign valid_o   = (usage_q != '0) && (count_q[rd_ptr_q] == '0);
  assign payload_o = payload_mem_q[rd_ptr_q];
  assign usage_o   = usage_q;

  // A clear cycle swallows both handshakes; the LFSR only sees real pushes.
  assign push_en = valid_i && ready_o && !clear_i;
  assign pop_en  = valid_o && ready_i && !clear_i;

  // --------------------------------------------------------------------------
  // Delay source
  // --------------------------------------------------------------------------
  if (DelayMode == DelayRandom) begin : g_lfsr
    lfsr_16bit #(
      .Seed     (Seed),
      .OutWidth (DelayWidth)
    ) u_lfsr (
      .clk_i   (clk_i),
      .rst_ni  (~rst_i),
      .en_i    (push_en),
      .value_o (lfsr_delay)
    );
  end else begin : g_no_lfsr
    assign lfsr_delay = '0;
  end

  always_comb begin
    push_delay = DelayWidth'(FixedDelay);
    case (DelayMode)
      DelayRandom: push_delay = lfsr_delay;
      DelayPort:   push_delay = delay_i;
      default:     push_delay = DelayWidth'(FixedDelay);
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    payload_mem_d = payload_mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    usage_d       = usage_q;

    // Every counter ages each cycle and saturates at zero. Free slots may be
    // aged too; that is harmless because a push always reloads its slot.
    for (int i = 0; i < Depth; i++) begin
      count_d[i] = (count_q[i] != '0) ? (count_q[i] - DelayWidth'(1)) : '0;
    end

    if (clear_i) begin
      for (int i = 0; i < Depth; i++) begin
        count_d[i] = '0;
      end
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (push_en) begin
        payload_mem_d[wr_ptr_q] = payload_i;
        count_d[wr_ptr_q]       = push_delay;
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : (wr_ptr_q + PtrWidth'(1));
      end
      if (pop_en) begin
        rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : (rd_ptr_q + PtrWidth'(1));
      end
      case ({push_en, pop_en})
        2'b10:   usage_d = usage_q + UsageWidth'(1);
        2'b01:   usage_d = usage_q - UsageWidth'(1);
        default: usage_d = usage_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
      count_q  <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
      count_q  <= count_d;
    end
  end

  // Payload contents are meaningless while their entry is free, so the
  // array carries no reset.
  always_ff @(posedge clk_i) begin
    payload_mem_q <= payload_mem_d;
  end

  // An offered beat must hold until it is taken (clear is the only escape).
  a_payload_stable : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i && !clear_i) |=> (valid_o && $stable(payload_o))
  ) else $error("stream_delay_fifo: offered beat changed before ready_i");

endmodule : stream_delay_fifo
`default_nettype wire

// File: tb/tb_stream_delay_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_delay_fifo
//  Description : Self-checking bench for stream_delay_fifo. Three instances:
//                A  fixed delay 3, Depth 3 (single beat, clear, async reset)
//                B  port delay,    Depth 4 (streaming, no-overtake)
//                C  LFSR delay,    Depth 2 (backpressure, random traffic)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_delay_fifo;
  import stream_delay_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A
  logic       clr_a, vi_a, ro_a, vo_a, ri_a;
  logic [7:0] pi_a, po_a;
  logic [3:0] di_a;
  logic [1:0] us_a;
  // Instance B
  logic       clr_b, vi_b, ro_b, vo_b, ri_b;
  logic [7:0] pi_b, po_b;
  logic [3:0] di_b;
  logic [2:0] us_b;
  // Instance C
  logic       clr_c, vi_c, ro_c, vo_c, ri_c;
  logic [7:0] pi_c, po_c;
  logic [3:0] di_c;
  logic [1:0] us_c;

  stream_delay_fifo #(
    .payload_t(logic [7:0]), .Depth(3), .DelayWidth(4),
    .DelayMode(DelayFixed), .FixedDelay(3), .Seed(16'h0001)
  ) u_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clr_a), .payload_i(pi_a), .valid_i(vi_a),
    .ready_o(ro_a), .delay_i(di_a), .payload_o(po_a), .valid_o(vo_a),
    .ready_i(ri_a), .usage_o(us_a)
  );

  stream_delay_fifo #(
    .payload_t(logic [7:0]), .Depth(4), .DelayWidth(4),
    .DelayMode(DelayPort), .FixedDelay(0), .Seed(16'h0001)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clr_b), .payload_i(pi_b), .valid_i(vi_b),
    .ready_o(ro_b), .delay_i(di_b), .payload_o(po_b), .valid_o(vo_b),
    .ready_i(ri_b), .usage_o(us_b)
  );

  stream_delay_fifo #(
    .payload_t(logic [7:0]), .Depth(2), .DelayWidth(4),
    .DelayMode(DelayRandom), .FixedDelay(0), .Seed(16'hACE1)
  ) u_c (
    .clk_i(clk), .rst_i(rst), .clear_i(clr_c), .payload_i(pi_c), .valid_i(vi_c),
    .ready_o(ro_c), .delay_i(di_c), .payload_o(po_c), .valid_o(vo_c),
    .ready_i(ri_c), .usage_o(us_c)
  );

  // Reference LFSR for instance C: x^16+x^14+x^13+x^11+1, shift right.
  logic [15:0] lfsr_m;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Reference beat: payload and the first cycle it may be offered.
  typedef struct {
    logic [7:0] pl;
    int         rel;
  } beat_t;

  task automatic test_reset();
    rst = 1'b1;
    {clr_a, vi_a, ri_a, pi_a, di_a} = '0;
    {clr_b, vi_b, ri_b, pi_b, di_b} = '0;
    {clr_c, vi_c, ri_c, pi_c, di_c} = '0;
    lfsr_m = 16'hACE1;
    @(negedge clk);
    checks++; if (ro_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %b want 1", ro_a); end
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b want 0", vo_a); end
    checks++; if (us_a !== 2'd0) begin errors++; $display("FAIL reset_usage_a: got %0d want 0", us_a); end
    checks++; if (ro_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b: got %b want 1", ro_b); end
    checks++; if (vo_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b want 0", vo_b); end
    checks++; if (us_b !== 3'd0) begin errors++; $display("FAIL reset_usage_b: got %0d want 0", us_b); end
    checks++; if (ro_c !== 1'b1) begin errors++; $display("FAIL reset_ready_c: got %b want 1", ro_c); end
    checks++; if (vo_c !== 1'b0) begin errors++; $display("FAIL reset_valid_c: got %b want 0", vo_c); end
    checks++; if (us_c !== 2'd0) begin errors++; $display("FAIL reset_usage_c: got %0d want 0", us_c); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One beat with fixed delay 3: offered exactly 4 cycles after its push.
  task automatic test_single_fixed();
    ri_a = 1'b1; vi_a = 1'b1; pi_a = 8'h5A;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vi_a = 1'b0;
      checks++; if (vo_a !== (k == 4)) begin errors++; $display("FAIL single_valid k=%0d: got %b want %b", k, vo_a, (k == 4)); end
      checks++; if (us_a !== ((k <= 4) ? 2'd1 : 2'd0)) begin errors++; $display("FAIL single_usage k=%0d: got %0d want %0d", k, us_a, (k <= 4) ? 1 : 0); end
      if (k == 4) begin
        checks++; if (po_a !== 8'h5A) begin errors++; $display("FAIL single_payload: got %h want 5a", po_a); end
      end
    end
  endtask

  // Fill A, flush it with clear (pending push/pop ignored), then async reset.
  task automatic test_clear_reset();
    ri_a = 1'b0; vi_a = 1'b1; pi_a = 8'hA0;
    @(negedge clk); pi_a = 8'hA1;
    @(negedge clk); pi_a = 8'hA2;
    @(negedge clk); pi_a = 8'hA3;
    checks++; if (ro_a !== 1'b0) begin errors++; $display("FAIL full_ready_a: got %b want 0", ro_a); end
    checks++; if (us_a !== 2'd3) begin errors++; $display("FAIL full_usage_a: got %0d want 3", us_a); end
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL early_valid_a: got %b want 0", vo_a); end
    @(negedge clk);
    checks++; if (vo_a !== 1'b1) begin errors++; $display("FAIL pre_clear_valid_a: got %b want 1", vo_a); end
    checks++; if (po_a !== 8'hA0) begin errors++; $display("FAIL pre_clear_payload_a: got %h want a0", po_a); end
    clr_a = 1'b1; ri_a = 1'b1; pi_a = 8'hA4;
    @(negedge clk);
    clr_a = 1'b0; vi_a = 1'b0;
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL clear_valid_a: got %b want 0", vo_a); end
    checks++; if (us_a !== 2'd0) begin errors++; $display("FAIL clear_usage_a: got %0d want 0", us_a); end
    checks++; if (ro_a !== 1'b1) begin errors++; $display("FAIL clear_ready_a: got %b want 1", ro_a); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (vo_a !== 1'b0 || us_a !== 2'd0) begin errors++; $display("FAIL post_clear_idle_a k=%0d: got valid %b usage %0d want 0 0", k, vo_a, us_a); end
    end
    // Two beats in flight, then reset mid-cycle.
    vi_a = 1'b1; pi_a = 8'hB0;
    @(negedge clk); pi_a = 8'hB1;
    @(negedge clk); vi_a = 1'b0;
    checks++; if (us_a !== 2'd2) begin errors++; $display("FAIL pre_reset_usage_a: got %0d want 2", us_a); end
    #1 rst = 1'b1;
    #1;
    checks++; if (ro_a !== 1'b1) begin errors++; $display("FAIL async_reset_ready_a: got %b want 1", ro_a); end
    checks++; if (us_a !== 2'd0) begin errors++; $display("FAIL async_reset_usage_a: got %0d want 0", us_a); end
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL async_reset_valid_a: got %b want 0", vo_a); end
    @(negedge clk);
    rst = 1'b0;
    lfsr_m = 16'hACE1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (vo_a !== 1'b0 || us_a !== 2'd0) begin errors++; $display("FAIL post_reset_idle_a k=%0d: got valid %b usage %0d want 0 0", k, vo_a, us_a); end
    end
  endtask

  // Constant delay 2 with valid_i and ready_i held high: one beat per cycle.
  task automatic test_back_to_back();
    ri_b = 1'b1; vi_b = 1'b1; di_b = 4'd2; pi_b = 8'd0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      pi_b = 8'(n);
      checks++; if (us_b !== 3'((n < 3) ? n : 3)) begin errors++; $display("FAIL stream_usage n=%0d: got %0d want %0d", n, us_b, (n < 3) ? n : 3); end
      checks++; if (ro_b !== 1'b1) begin errors++; $display("FAIL stream_ready n=%0d: got %b want 1", n, ro_b); end
      checks++; if (vo_b !== (n >= 3)) begin errors++; $display("FAIL stream_valid n=%0d: got %b want %b", n, vo_b, (n >= 3)); end
      if (n >= 3) begin
        checks++; if (po_b !== 8'(n - 3)) begin errors++; $display("FAIL stream_payload n=%0d: got %0d want %0d", n, po_b, n - 3); end
      end
    end
    @(negedge clk); vi_b = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (us_b !== 3'd0) begin errors++; $display("FAIL stream_drain_usage: got %0d want 0", us_b); end
  endtask

  // Delay 5 then delay 0: the younger beat waits behind the head.
  task automatic test_no_overtake();
    ri_b = 1'b1; vi_b = 1'b1; pi_b = 8'hAA; di_b = 4'd5;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin pi_b = 8'hBB; di_b = 4'd0; end
      else vi_b = 1'b0;
      checks++; if (vo_b !== (k == 6 || k == 7)) begin errors++; $display("FAIL order_valid k=%0d: got %b want %b", k, vo_b, (k == 6 || k == 7)); end
      if (k == 6) begin checks++; if (po_b !== 8'hAA) begin errors++; $display("FAIL order_first: got %h want aa", po_b); end end
      if (k == 7) begin checks++; if (po_b !== 8'hBB) begin errors++; $display("FAIL order_second: got %h want bb", po_b); end end
    end
  endtask

  // Depth 2 under backpressure, then same-cycle push and pop.
  task automatic test_backpressure();
    int d3;
    ri_c = 1'b0; vi_c = 1'b1; pi_c = 8'd1;
    lfsr_m = lfsr_next(lfsr_m);
    @(negedge clk); pi_c = 8'd2;
    checks++; if (ro_c !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b want 1", ro_c); end
    lfsr_m = lfsr_next(lfsr_m);
    @(negedge clk); pi_c = 8'd3;
    checks++; if (ro_c !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", ro_c); end
    checks++; if (us_c !== 2'd2) begin errors++; $display("FAIL bp_usage_full: got %0d want 2", us_c); end
    repeat (18) @(negedge clk);
    checks++; if (us_c !== 2'd2 || ro_c !== 1'b0) begin errors++; $display("FAIL bp_hold: got usage %0d ready %b want 2 0", us_c, ro_c); end
    checks++; if (vo_c !== 1'b1 || po_c !== 8'd1) begin errors++; $display("FAIL bp_head: got valid %b payload %0d want 1 1", vo_c, po_c); end
    ri_c = 1'b1;
    @(negedge clk);
    checks++; if (us_c !== 2'd1 || ro_c !== 1'b1) begin errors++; $display("FAIL bp_after_pop: got usage %0d ready %b want 1 1", us_c, ro_c); end
    checks++; if (vo_c !== 1'b1 || po_c !== 8'd2) begin errors++; $display("FAIL bp_second: got valid %b payload %0d want 1 2", vo_c, po_c); end
    d3 = int'(lfsr_m[3:0]);
    lfsr_m = lfsr_next(lfsr_m);
    @(negedge clk); vi_c = 1'b0;
    checks++; if (us_c !== 2'd1) begin errors++; $display("FAIL bp_push_pop_usage: got %0d want 1", us_c); end
    for (int k = 0; k <= d3; k++) begin
      checks++; if (vo_c !== (k == d3)) begin errors++; $display("FAIL bp_third_valid k=%0d: got %b want %b", k, vo_c, (k == d3)); end
      if (k == d3) begin checks++; if (po_c !== 8'd3) begin errors++; $display("FAIL bp_third_payload: got %0d want 3", po_c); end end
      @(negedge clk);
    end
    checks++; if (us_c !== 2'd0) begin errors++; $display("FAIL bp_empty: got %0d want 0", us_c); end
  endtask

  // 100 random beats with random backpressure against a queue model.
  task automatic test_random_lfsr();
    beat_t q[$];
    int    now = 0;
    int    pushes = 0;
    bit    exp_valid, exp_ready;
    while (!(pushes == 100 && q.size() == 0) && now < 3000) begin
      @(negedge clk);
      vi_c = (pushes < 100) && ($urandom_range(0, 3) != 0);
      pi_c = 8'($urandom);
      ri_c = ($urandom_range(0, 2) != 0);
      exp_ready = (q.size() < 2);
      exp_valid = (q.size() > 0) && (now >= q[0].rel);
      checks++; if (ro_c !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d: got %b want %b", now, ro_c, exp_ready); end
      checks++; if (vo_c !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d: got %b want %b", now, vo_c, exp_valid); end
      checks++; if (us_c !== 2'(q.size())) begin errors++; $display("FAIL rnd_usage cyc=%0d: got %0d want %0d", now, us_c, q.size()); end
      if (exp_valid) begin
        checks++; if (po_c !== q[0].pl) begin errors++; $display("FAIL rnd_payload cyc=%0d: got %h want %h", now, po_c, q[0].pl); end
      end
      if (exp_valid && ri_c) void'(q.pop_front());
      if (vi_c && exp_ready) begin
        q.push_back('{pl: pi_c, rel: now + 1 + int'(lfsr_m[3:0])});
        lfsr_m = lfsr_next(lfsr_m);
        pushes++;
      end
      now++;
    end
    vi_c = 1'b0; ri_c = 1'b0;
    if (pushes != 100 || q.size() != 0) begin
      checks++; errors++;
      $display("FAIL rnd_timeout: got %0d pushes %0d pending want 100 0", pushes, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_fixed();
    test_clear_reset();
    test_back_to_back();
    test_no_overtake();
    test_backpressure();
    test_random_lfsr();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_stream_delay_fifo
`default_nettype wire
